// File: rtl/integer_divide_32bit.sv
// Iterative restoring divider for the RISC-V M-extension DIV/DIVU/REM/REMU ops.
// Produces one quotient bit per clock. Divide-by-zero and signed overflow are
// resolved at accept time and finish after a single cycle. The result register
// holds its value between operations.
module integer_divide_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] rem;          // partial remainder (always < divisor_mag)
  logic [WIDTH-1:0] quo;          // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] divisor_mag;
  logic             neg_quo;
  logic             neg_rem;
  logic             want_rem;
  logic [CW-1:0]    count;

  // Accept-time decode: signedness, magnitudes and the two special cases
  logic             dividend_neg;
  logic             divisor_neg;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag_in;
  logic             div_by_zero;
  logic             overflow;
  logic [WIDTH-1:0] special_result;

  // Datapath for one restoring step and the final sign fix-up
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] final_quo;
  logic [WIDTH-1:0] final_rem;
  logic             last_step;

  // Operand decode for a new request
  always_comb begin
    dividend_neg   = ~op[0] & dividend[WIDTH-1];
    divisor_neg    = ~op[0] & divisor[WIDTH-1];
    dividend_mag   = dividend_neg ? (~dividend + 1'b1) : dividend;
    divisor_mag_in = divisor_neg  ? (~divisor + 1'b1)  : divisor;
    div_by_zero    = (divisor == '0);
    overflow       = ~op[0] & (dividend == MIN_INT) & (divisor == '1);
    if (div_by_zero) begin
      special_result = op[1] ? dividend : '1;
    end else begin
      special_result = op[1] ? '0 : dividend;
    end
  end

  // One restoring step: shift in the next dividend bit, subtract, keep if non-negative
  always_comb begin
    shifted   = {rem, quo[WIDTH-1]};
    trial     = shifted - {1'b0, divisor_mag};
    step_rem  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    step_quo  = {quo[WIDTH-2:0], ~trial[WIDTH]};
    final_quo = neg_quo ? (~step_quo + 1'b1) : step_quo;
    final_rem = neg_rem ? (~step_rem + 1'b1) : step_rem;
    last_step = (count == CW'(WIDTH - 1));
  end

  // Control FSM with registered busy/done/result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      rem         <= '0;
      quo         <= '0;
      divisor_mag <= '0;
      neg_quo     <= 1'b0;
      neg_rem     <= 1'b0;
      want_rem    <= 1'b0;
      count       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        CALC: begin
          rem   <= step_rem;
          quo   <= step_quo;
          count <= count + 1'b1;
          if (last_step) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= want_rem ? final_rem : final_quo;
          end
        end
        IDLE, DONE: begin
          if (start) begin
            want_rem <= op[1];
            neg_quo  <= dividend_neg ^ divisor_neg;
            neg_rem  <= dividend_neg;
            if (div_by_zero || overflow) begin
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              result <= special_result;
            end else begin
              state       <= CALC;
              busy        <= 1'b1;
              rem         <= '0;
              quo         <= dividend_mag;
              divisor_mag <= divisor_mag_in;
              count       <= '0;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_integer_divide_32bit.sv
// Self-checking bench for integer_divide_32bit: directed RISC-V cases plus
// randomized operations checked against a plain-arithmetic reference model.
module tb_integer_divide_32bit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;

  integer_divide_32bit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: RISC-V divide semantics using the simulator's own arithmetic
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'h0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : a;
    case (o)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'h0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Drive one request and observe it: samples taken 1ns after each rising edge,
  // sample 1 is the cycle after the accepting edge. lat = first sample with done.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int busy_cnt, output int done_cnt, output int lat);
    @(negedge clk);
    start = 1'b1; op = o; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cnt = 0; done_cnt = 0; lat = -1; res = result;
    for (int i = 1; i <= 60; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat < 0) begin
          lat = i;
          res = result;
        end
      end
      if (lat >= 0 && i >= lat + 2) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      n_err++;
      $display("FAIL reset_hold: busy=%b done=%b result=%h required 0 0 00000000", busy, done, result);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      n_err++;
      $display("FAIL reset_release: busy=%b done=%b result=%h required 0 0 00000000", busy, done, result);
    end
    $display("reset: busy=%b done=%b result=%h", busy, done, result);
  endtask

  task automatic test_unsigned();
    logic [31:0] r; int bc, dc, lat;
    do_op(2'b01, 32'd100, 32'd7, r, bc, dc, lat);
    $display("DIVU 100/7: result=%h busy_cycles=%0d dones=%0d lat=%0d", r, bc, dc, lat);
    n_cmp++;
    if (r !== 32'd14) begin n_err++; $display("FAIL divu_result: got %h required %h", r, 32'd14); end
    n_cmp++;
    if (bc != 32 || dc != 1 || lat != 33) begin
      n_err++; $display("FAIL divu_timing: busy=%0d dones=%0d lat=%0d required 32 1 33", bc, dc, lat);
    end
    do_op(2'b11, 32'd100, 32'd7, r, bc, dc, lat);
    $display("REMU 100/7: result=%h lat=%0d", r, lat);
    n_cmp++;
    if (r !== 32'd2 || lat != 33) begin n_err++; $display("FAIL remu_result: got %h lat %0d required 00000002 lat 33", r, lat); end
  endtask

  task automatic test_signed();
    logic [31:0] r; int bc, dc, lat;
    do_op(2'b00, 32'hFFFF_FFF9, 32'd2, r, bc, dc, lat);
    $display("DIV -7/2: result=%h", r);
    n_cmp++;
    if (r !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_neg_dividend: got %h required fffffffd", r); end
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, r, bc, dc, lat);
    $display("REM -7/2: result=%h", r);
    n_cmp++;
    if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rem_neg_dividend: got %h required ffffffff", r); end
    do_op(2'b00, 32'd7, 32'hFFFF_FFFE, r, bc, dc, lat);
    $display("DIV 7/-2: result=%h", r);
    n_cmp++;
    if (r !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_neg_divisor: got %h required fffffffd", r); end
  endtask

  task automatic test_div_by_zero();
    logic [31:0] r; int bc, dc, lat;
    do_op(2'b01, 32'd5, 32'd0, r, bc, dc, lat);
    $display("DIVU 5/0: result=%h busy_cycles=%0d lat=%0d", r, bc, lat);
    n_cmp++;
    if (r !== 32'hFFFF_FFFF || bc != 0 || dc != 1 || lat != 1) begin
      n_err++; $display("FAIL divu_by_zero: result=%h busy=%0d dones=%0d lat=%0d required ffffffff 0 1 1", r, bc, dc, lat);
    end
    do_op(2'b10, 32'd5, 32'd0, r, bc, dc, lat);
    $display("REM 5/0: result=%h busy_cycles=%0d lat=%0d", r, bc, lat);
    n_cmp++;
    if (r !== 32'd5 || bc != 0 || lat != 1) begin
      n_err++; $display("FAIL rem_by_zero: result=%h busy=%0d lat=%0d required 00000005 0 1", r, bc, lat);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] r; int bc, dc, lat;
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, r, bc, dc, lat);
    $display("DIV min/-1: result=%h busy_cycles=%0d lat=%0d", r, bc, lat);
    n_cmp++;
    if (r !== 32'h8000_0000 || bc != 0 || dc != 1 || lat != 1) begin
      n_err++; $display("FAIL div_overflow: result=%h busy=%0d dones=%0d lat=%0d required 80000000 0 1 1", r, bc, dc, lat);
    end
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, r, bc, dc, lat);
    $display("REM min/-1: result=%h lat=%0d", r, lat);
    n_cmp++;
    if (r !== 32'h0 || lat != 1) begin n_err++; $display("FAIL rem_overflow: result=%h lat=%0d required 00000000 1", r, lat); end
  endtask

  task automatic test_ignore_start();
    logic [31:0] r; int dc, lat;
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'hFFFF_FFFF; divisor = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    dc = 0; lat = -1; r = '0;
    for (int i = 1; i <= 45; i++) begin
      if (done) begin
        dc++;
        if (lat < 0) begin lat = i; r = result; end
      end
      if (i == 10) begin
        start = 1'b1; op = 2'b00; dividend = 32'd5; divisor = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    $display("DIVU ffffffff/1 with start at cycle 10: result=%h dones=%0d lat=%0d", r, dc, lat);
    n_cmp++;
    if (r !== 32'hFFFF_FFFF || dc != 1 || lat != 33) begin
      n_err++; $display("FAIL start_ignored: result=%h dones=%0d lat=%0d required ffffffff 1 33", r, dc, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2; int lat1, lat2; logic busy1;
    @(negedge clk);
    start = 1'b1; op = 2'b00; dividend = 32'hFFFF_FF9C; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    lat1 = -1; r1 = '0;
    for (int i = 1; i <= 40; i++) begin
      if (done) begin lat1 = i; r1 = result; break; end
      @(posedge clk); #1;
    end
    // Request during the done cycle
    start = 1'b1; op = 2'b11; dividend = 32'd1000; divisor = 32'd33;
    @(posedge clk); #1;
    start = 1'b0;
    busy1 = busy;
    lat2 = -1; r2 = '0;
    for (int i = 1; i <= 40; i++) begin
      if (done) begin lat2 = i; r2 = result; break; end
      @(posedge clk); #1;
    end
    $display("back_to_back: DIV -100/7=%h lat=%0d ; REMU 1000/33=%h lat=%0d busy_after_accept=%b", r1, lat1, r2, lat2, busy1);
    n_cmp++;
    if (r1 !== 32'hFFFF_FFF2 || lat1 != 33) begin
      n_err++; $display("FAIL b2b_first: result=%h lat=%0d required fffffff2 33", r1, lat1);
    end
    n_cmp++;
    if (r2 !== 32'd10 || lat2 != 33 || busy1 !== 1'b1) begin
      n_err++; $display("FAIL b2b_second: result=%h lat=%0d busy=%b required 0000000a 33 1", r2, lat2, busy1);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] r; int bc, dc, lat, stray;
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'd123456; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    $display("reset mid-op: busy=%b done=%b result=%h", busy, done, result);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      n_err++; $display("FAIL reset_mid_op: busy=%b done=%b result=%h required 0 0 00000000", busy, done, result);
    end
    @(negedge clk); rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) stray++;
    end
    n_cmp++;
    if (stray != 0) begin n_err++; $display("FAIL aborted_done: done pulses=%0d required 0", stray); end
    do_op(2'b01, 32'd1000, 32'd10, r, bc, dc, lat);
    $display("after reset DIVU 1000/10: result=%h lat=%0d", r, lat);
    n_cmp++;
    if (r !== 32'd100 || lat != 33) begin n_err++; $display("FAIL post_reset_op: result=%h lat=%0d required 00000064 33", r, lat); end
  endtask

  task automatic test_random();
    logic [31:0] r, a, b, exp_r; logic [1:0] o; int bc, dc, lat, exp_lat;
    for (int n = 0; n < 40; n++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 15));
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4: b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      exp_r   = model(o, a, b);
      exp_lat = is_special(o, a, b) ? 1 : 33;
      do_op(o, a, b, r, bc, dc, lat);
      $display("random op=%0d a=%h b=%h result=%h expected=%h lat=%0d", o, a, b, r, exp_r, lat);
      n_cmp++;
      if (r !== exp_r || lat != exp_lat || dc != 1) begin
        n_err++;
        $display("FAIL random_%0d: result=%h lat=%0d dones=%0d required %h %0d 1", n, r, lat, dc, exp_r, exp_lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
